jelly_img_gray_adaptive_binarizer: RTL and testbench
====================================================

Name: jelly_img_gray_adaptive_binarizer

Overview:
- Downstream stage of the RGB-to-gray converter; consumes its gray pixel stream and frame markers.
- Binarizes each pixel against a per-frame adaptive threshold, (min+max)/2 of the previous frame.
- Accumulates per-frame gray statistics (min, max, sum, count) and publishes them at frame end for software/AE use.
- Image stream passes through with fixed 1-cycle latency.

Parameters:
- USER_WIDTH, 0, width of sideband user field (0 = unused)
- DATA_WIDTH, 8, gray pixel width
- SUM_WIDTH, 32, frame sum accumulator width (saturating)
- COUNT_WIDTH, 24, frame pixel counter width (saturating)
- INIT_THRESHOLD, 2**(DATA_WIDTH-1), threshold after reset
- USER_BITS, USER_WIDTH>0 ? USER_WIDTH : 1, derived

Ports:
- reset  in  1  synchronous active-high reset
- clk  in  1  single clock; all logic on posedge
- cke  in  1  clock enable; all state holds when 0
- s_img_line_first / s_img_line_last / s_img_pixel_first / s_img_pixel_last  in  1 each  frame markers
- s_img_de  in  1  data enable (active pixel)
- s_img_user  in  USER_BITS  sideband
- s_img_gray  in  DATA_WIDTH  gray pixel
- s_img_valid  in  1  stream valid
- m_img_line_first / line_last / pixel_first / pixel_last / de / user / gray / valid  out  as inputs  delayed copies
- m_img_binary  out  1  1 when gray >= current threshold
- m_stat_min  out  DATA_WIDTH  last frame minimum
- m_stat_max  out  DATA_WIDTH  last frame maximum
- m_stat_sum  out  SUM_WIDTH  last frame sum
- m_stat_count  out  COUNT_WIDTH  last frame active-pixel count
- m_stat_threshold  out  DATA_WIDTH  threshold currently applied
- m_stat_valid  out  1  one-cycle strobe: new stats published

Behaviour:
- Reset: m_img_valid=0, m_stat_valid=0, m_stat_min/max/sum/count=0, threshold=INIT_THRESHOLD. Accumulators go idle: min=all-ones, max=0, sum=0, count=0. Other m_img_* outputs don't-care.
- Qualifier: all updates occur only when cke=1. A pixel counts when valid=1 and de=1.
- Pass-through latency: 1 cycle. m_img_binary is computed against the threshold register as it stood when the pixel was sampled.
- Frame start: valid & line_first & pixel_first.
  - Accumulators reload from the idle values, then fold in the current pixel if de=1 (min=max=gray, sum=gray, count=1).
  - A start mid-frame discards the partial frame with no strobe.
- Other counted pixels: min=min(min,gray), max=max(max,gray), sum+=gray, count+=1.
- Saturation: sum and count saturate at all-ones and never wrap.
- Frame end: valid & line_last & pixel_last. On the next cycle (after the cke edge):
  - m_stat_* take the final values, including the end pixel if counted.
  - m_stat_valid=1 for exactly that one cke-enabled cycle. It stays 1 while cke=0 and clears on the next cke=1 edge.
  - Accumulators return to idle.
- Threshold update at frame end:
  - threshold = (min+max)>>1, computed in DATA_WIDTH+1 bits.
  - Applies to pixels sampled after the end pixel.
  - If final count=0: stats still publish (min=all-ones, max=0, sum=0, count=0), threshold unchanged.
- Single-pixel frame (start and end on the same beat): accumulators reload and publish in the same step; stats = that pixel, count=1.
- End without a preceding start after reset publishes whatever has been accumulated since idle.
- Two-register structure: accumulators are separate from published stats, so a new frame can start the cycle after an end with no bubble.

Test Plan:
- Default params, 4x2 frame with de=1, gray {10,20,30,40,50,60,70,200}:
  - m_img_* delayed 1 cycle; binary vs 128 = 0,0,0,0,0,0,0,1.
  - Strobe gives min=10, max=200, sum=480, count=8, threshold=105.
  - Next frame uses 105.
- Same frame with de=0 on the pixels holding 10 and 200 -> min=20, max=70, sum=270, count=6, threshold=45. Gated pixels still pass through with m_img_de=0.
- Single-pixel frame, gray=77 -> min=max=77, sum=77, count=1, threshold=77, one strobe. Then an all-de=0 frame -> count=0 published, threshold stays 77.
- cke toggled 0 pseudo-randomly through a frame and around frame end:
  - Results are identical to the cke=1 run.
  - m_stat_valid is held across cke=0 cycles and lasts one enabled cycle.
- SUM_WIDTH=10, COUNT_WIDTH=3, 12 pixels of 255 -> sum=1023, count=7 (saturated), threshold=255.
- Reset asserted mid-frame:
  - Next cycle m_img_valid=0, stats=0, threshold=INIT_THRESHOLD.
  - A following complete frame publishes only its own pixels.

Source files
------------

// File: rtl/jelly_img_gray_adaptive_binarizer.sv
// Gray-stream binarizer using a per-frame adaptive threshold ((min+max)/2 of the previous frame).
// Publishes per-frame gray statistics at frame end; pixels pass through with one cycle of latency.

module jelly_img_gray_adaptive_binarizer #(
    parameter int USER_WIDTH     = 0,
    parameter int DATA_WIDTH     = 8,
    parameter int SUM_WIDTH      = 32,
    parameter int COUNT_WIDTH    = 24,
    parameter int INIT_THRESHOLD = 2 ** (DATA_WIDTH - 1),
    parameter int USER_BITS      = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   cke,

    input  logic                   s_img_line_first,
    input  logic                   s_img_line_last,
    input  logic                   s_img_pixel_first,
    input  logic                   s_img_pixel_last,
    input  logic                   s_img_de,
    input  logic [USER_BITS-1:0]   s_img_user,
    input  logic [DATA_WIDTH-1:0]  s_img_gray,
    input  logic                   s_img_valid,

    output logic                   m_img_line_first,
    output logic                   m_img_line_last,
    output logic                   m_img_pixel_first,
    output logic                   m_img_pixel_last,
    output logic                   m_img_de,
    output logic [USER_BITS-1:0]   m_img_user,
    output logic [DATA_WIDTH-1:0]  m_img_gray,
    output logic                   m_img_binary,
    output logic                   m_img_valid,

    output logic [DATA_WIDTH-1:0]  m_stat_min,
    output logic [DATA_WIDTH-1:0]  m_stat_max,
    output logic [SUM_WIDTH-1:0]   m_stat_sum,
    output logic [COUNT_WIDTH-1:0] m_stat_count,
    output logic [DATA_WIDTH-1:0]  m_stat_threshold,
    output logic                   m_stat_valid
);

    localparam logic [DATA_WIDTH-1:0]  DATA_ONES  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]  DATA_ZERO  = {DATA_WIDTH{1'b0}};
    localparam logic [SUM_WIDTH-1:0]   SUM_ONES   = {SUM_WIDTH{1'b1}};
    localparam logic [SUM_WIDTH-1:0]   SUM_ZERO   = {SUM_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONES = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1'b1);

    logic [DATA_WIDTH-1:0]  acc_min_r;
    logic [DATA_WIDTH-1:0]  acc_max_r;
    logic [SUM_WIDTH-1:0]   acc_sum_r;
    logic [COUNT_WIDTH-1:0] acc_count_r;

    logic                   counted_s;
    logic                   frame_start_s;
    logic                   frame_end_s;
    logic [DATA_WIDTH-1:0]  base_min_s;
    logic [DATA_WIDTH-1:0]  base_max_s;
    logic [SUM_WIDTH-1:0]   base_sum_s;
    logic [COUNT_WIDTH-1:0] base_count_s;
    logic [SUM_WIDTH:0]     sum_ext_s;
    logic [DATA_WIDTH-1:0]  next_min_s;
    logic [DATA_WIDTH-1:0]  next_max_s;
    logic [SUM_WIDTH-1:0]   next_sum_s;
    logic [COUNT_WIDTH-1:0] next_count_s;
    logic [DATA_WIDTH-1:0]  next_threshold_s;

    // Fold the current beat into the accumulators; a frame start restarts them from idle first.
    always_comb begin
        counted_s     = s_img_valid & s_img_de;
        frame_start_s = s_img_valid & s_img_line_first & s_img_pixel_first;
        frame_end_s   = s_img_valid & s_img_line_last & s_img_pixel_last;

        if (frame_start_s) begin
            base_min_s   = DATA_ONES;
            base_max_s   = DATA_ZERO;
            base_sum_s   = SUM_ZERO;
            base_count_s = COUNT_ZERO;
        end else begin
            base_min_s   = acc_min_r;
            base_max_s   = acc_max_r;
            base_sum_s   = acc_sum_r;
            base_count_s = acc_count_r;
        end

        sum_ext_s    = {1'b0, base_sum_s} + (SUM_WIDTH + 1)'(s_img_gray);
        next_min_s   = base_min_s;
        next_max_s   = base_max_s;
        next_sum_s   = base_sum_s;
        next_count_s = base_count_s;

        if (counted_s) begin
            if (s_img_gray < base_min_s) begin
                next_min_s = s_img_gray;
            end else begin
                next_min_s = base_min_s;
            end
            if (s_img_gray > base_max_s) begin
                next_max_s = s_img_gray;
            end else begin
                next_max_s = base_max_s;
            end
            // Carry out of the widened sum means the accumulator would wrap: pin it instead.
            if (sum_ext_s[SUM_WIDTH]) begin
                next_sum_s = SUM_ONES;
            end else begin
                next_sum_s = sum_ext_s[SUM_WIDTH-1:0];
            end
            if (base_count_s == COUNT_ONES) begin
                next_count_s = COUNT_ONES;
            end else begin
                next_count_s = base_count_s + COUNT_ONE;
            end
        end else begin
            next_min_s   = base_min_s;
            next_max_s   = base_max_s;
            next_sum_s   = base_sum_s;
            next_count_s = base_count_s;
        end

        next_threshold_s = DATA_WIDTH'(({1'b0, next_min_s} + {1'b0, next_max_s}) >> 1);
    end

    // Pass-through pipeline, accumulator update and frame-end publication of stats/threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_img_valid      <= 1'b0;
            m_stat_valid     <= 1'b0;
            m_stat_min       <= DATA_ZERO;
            m_stat_max       <= DATA_ZERO;
            m_stat_sum       <= SUM_ZERO;
            m_stat_count     <= COUNT_ZERO;
            m_stat_threshold <= DATA_WIDTH'(INIT_THRESHOLD);
            acc_min_r        <= DATA_ONES;
            acc_max_r        <= DATA_ZERO;
            acc_sum_r        <= SUM_ZERO;
            acc_count_r      <= COUNT_ZERO;
        end else if (cke) begin
            m_img_line_first  <= s_img_line_first;
            m_img_line_last   <= s_img_line_last;
            m_img_pixel_first <= s_img_pixel_first;
            m_img_pixel_last  <= s_img_pixel_last;
            m_img_de          <= s_img_de;
            m_img_user        <= s_img_user;
            m_img_gray        <= s_img_gray;
            m_img_valid       <= s_img_valid;
            m_img_binary      <= (s_img_gray >= m_stat_threshold);

            if (frame_end_s) begin
                m_stat_min   <= next_min_s;
                m_stat_max   <= next_max_s;
                m_stat_sum   <= next_sum_s;
                m_stat_count <= next_count_s;
                m_stat_valid <= 1'b1;
                // An empty frame carries no information about the scene, so keep the old threshold.
                if (next_count_s != COUNT_ZERO) begin
                    m_stat_threshold <= next_threshold_s;
                end
                acc_min_r   <= DATA_ONES;
                acc_max_r   <= DATA_ZERO;
                acc_sum_r   <= SUM_ZERO;
                acc_count_r <= COUNT_ZERO;
            end else begin
                m_stat_valid <= 1'b0;
                acc_min_r    <= next_min_s;
                acc_max_r    <= next_max_s;
                acc_sum_r    <= next_sum_s;
                acc_count_r  <= next_count_s;
            end
        end
    end

endmodule

// File: tb/tb_jelly_img_gray_adaptive_binarizer.sv
// Scoreboard bench for the adaptive binarizer: a default instance and a narrow-accumulator
// instance share one randomized stream; a list-based frame model predicts every output.

module tb_jelly_img_gray_adaptive_binarizer;

    typedef struct packed {
        logic       lf, ll, pf, pl, de;
        logic [0:0] user;
        logic [7:0] gray;
        logic       bin;
    } pix_t;

    typedef struct packed {
        logic [7:0]  mn, mx;
        logic [63:0] sum;
        logic [63:0] cnt;
        logic [7:0]  thr;
    } stat_t;

    logic clk = 1'b0;
    logic reset, cke;
    logic lf, ll, pf, pl, de, valid;
    logic [0:0] user;
    logic [7:0] gray;

    logic a_lf, a_ll, a_pf, a_pl, a_de, a_bin, a_valid, a_sv;
    logic [0:0] a_user;
    logic [7:0] a_gray, a_min, a_max, a_thr;
    logic [31:0] a_sum;
    logic [23:0] a_cnt;

    logic b_lf, b_ll, b_pf, b_pl, b_de, b_bin, b_valid, b_sv;
    logic [0:0] b_user;
    logic [7:0] b_gray, b_min, b_max, b_thr;
    logic [9:0] b_sum;
    logic [2:0] b_cnt;

    always #5 clk = ~clk;

    jelly_img_gray_adaptive_binarizer dut_a (
        .reset(reset), .clk(clk), .cke(cke),
        .s_img_line_first(lf), .s_img_line_last(ll), .s_img_pixel_first(pf), .s_img_pixel_last(pl),
        .s_img_de(de), .s_img_user(user), .s_img_gray(gray), .s_img_valid(valid),
        .m_img_line_first(a_lf), .m_img_line_last(a_ll), .m_img_pixel_first(a_pf),
        .m_img_pixel_last(a_pl), .m_img_de(a_de), .m_img_user(a_user), .m_img_gray(a_gray),
        .m_img_binary(a_bin), .m_img_valid(a_valid),
        .m_stat_min(a_min), .m_stat_max(a_max), .m_stat_sum(a_sum), .m_stat_count(a_cnt),
        .m_stat_threshold(a_thr), .m_stat_valid(a_sv)
    );

    jelly_img_gray_adaptive_binarizer #(.SUM_WIDTH(10), .COUNT_WIDTH(3)) dut_b (
        .reset(reset), .clk(clk), .cke(cke),
        .s_img_line_first(lf), .s_img_line_last(ll), .s_img_pixel_first(pf), .s_img_pixel_last(pl),
        .s_img_de(de), .s_img_user(user), .s_img_gray(gray), .s_img_valid(valid),
        .m_img_line_first(b_lf), .m_img_line_last(b_ll), .m_img_pixel_first(b_pf),
        .m_img_pixel_last(b_pl), .m_img_de(b_de), .m_img_user(b_user), .m_img_gray(b_gray),
        .m_img_binary(b_bin), .m_img_valid(b_valid),
        .m_stat_min(b_min), .m_stat_max(b_max), .m_stat_sum(b_sum), .m_stat_count(b_cnt),
        .m_stat_threshold(b_thr), .m_stat_valid(b_sv)
    );

    pix_t  pix_q[$];
    stat_t stat_q[$];
    int    acc_q[$];
    int    model_thr;
    int    tests = 0;
    int    fails = 0;
    bit    done = 1'b0;
    bit    cke_mode, gap_mode;
    logic [7:0] fr_gray [64];
    bit         fr_de   [64];
    logic [7:0] pat     [8];

    function automatic logic [63:0] sat(input logic [63:0] v, input int w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a frame is just the list of counted gray values since its start.
    task automatic model_issue(input logic lf_, ll_, pf_, pl_, de_, input logic [0:0] u_,
                               input logic [7:0] g_);
        pix_t  p;
        stat_t s;
        int    mn, mx;
        longint sm;
        p = '{lf: lf_, ll: ll_, pf: pf_, pl: pl_, de: de_, user: u_, gray: g_,
              bin: (int'(g_) >= model_thr)};
        pix_q.push_back(p);
        if (lf_ && pf_) acc_q.delete();
        if (de_) acc_q.push_back(int'(g_));
        if (ll_ && pl_) begin
            mn = 255; mx = 0; sm = 0;
            foreach (acc_q[i]) begin
                if (acc_q[i] < mn) mn = acc_q[i];
                if (acc_q[i] > mx) mx = acc_q[i];
                sm += acc_q[i];
            end
            if (acc_q.size() > 0) model_thr = (mn + mx) / 2;
            s.mn  = 8'(mn);
            s.mx  = 8'(mx);
            s.sum = 64'(sm);
            s.cnt = 64'(acc_q.size());
            s.thr = 8'(model_thr);
            stat_q.push_back(s);
            acc_q.delete();
        end
    endtask

    task automatic tick_cke();
        cke = cke_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic send_beat(input logic lf_, ll_, pf_, pl_, de_, input logic [7:0] g_);
        logic [0:0] u_;
        bit taken;
        u_ = 1'($urandom_range(0, 1));
        taken = 1'b0;
        lf = lf_; ll = ll_; pf = pf_; pl = pl_; de = de_; gray = g_; user = u_; valid = 1'b1;
        while (!taken) begin
            tick_cke();
            if (cke) model_issue(lf_, ll_, pf_, pl_, de_, u_, g_);
            taken = cke;
            @(negedge clk);
        end
        valid = 1'b0; lf = 1'b0; ll = 1'b0; pf = 1'b0; pl = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            tick_cke();
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int w, input int h, input int first, input int n);
        int x, y;
        for (int i = first; i < n; i++) begin
            x = i % w;
            y = i / w;
            send_beat(y == 0, y == h - 1, x == 0, x == w - 1, fr_de[i], fr_gray[i]);
            if (gap_mode && $urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 8; i++) begin
            fr_gray[i] = pat[i];
            fr_de[i]   = 1'b1;
        end
    endtask

    task automatic do_reset();
        valid = 1'b0;
        cke = 1'b1;
        reset = 1'b1;
        model_thr = 128;
        acc_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cmp_pix(input string t, input logic lf_, ll_, pf_, pl_, de_,
                           input logic [0:0] u_, input logic [7:0] g_, input logic bin_,
                           input pix_t e);
        chk({t, "_line_first"}, lf_, e.lf);
        chk({t, "_line_last"}, ll_, e.ll);
        chk({t, "_pixel_first"}, pf_, e.pf);
        chk({t, "_pixel_last"}, pl_, e.pl);
        chk({t, "_de"}, de_, e.de);
        chk({t, "_user"}, u_, e.user);
        chk({t, "_gray"}, g_, e.gray);
        chk({t, "_binary"}, bin_, e.bin);
    endtask

    task automatic cmp_stat(input string t, input logic [7:0] mn, mx, input logic [63:0] sm, cn,
                            input logic [7:0] th, input stat_t e, input int sw, input int cw);
        chk({t, "_min"}, mn, e.mn);
        chk({t, "_max"}, mx, e.mx);
        chk({t, "_sum"}, sm, sat(e.sum, sw));
        chk({t, "_count"}, cn, sat(e.cnt, cw));
        chk({t, "_threshold"}, th, e.thr);
    endtask

    logic cke_q = 1'b0;
    logic rst_q = 1'b0;
    logic sv_prev_a = 1'b0;
    logic sv_prev_b = 1'b0;

    always @(posedge clk) begin
        cke_q <= cke;
        rst_q <= reset;
    end

    // Monitor: compares whatever the DUTs present after each edge against the scoreboard.
    always @(negedge clk) begin
        pix_t  ep;
        stat_t es;
        if (done) begin
            chk("pixel_queue_drained", 64'(pix_q.size()), 64'd0);
            chk("stat_queue_drained", 64'(stat_q.size()), 64'd0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end else if (rst_q) begin
            chk("rst_a_img_valid", a_valid, 1'b0);
            chk("rst_a_stat_valid", a_sv, 1'b0);
            chk("rst_a_min", a_min, 8'd0);
            chk("rst_a_max", a_max, 8'd0);
            chk("rst_a_sum", a_sum, 32'd0);
            chk("rst_a_count", a_cnt, 24'd0);
            chk("rst_a_threshold", a_thr, 8'd128);
            chk("rst_b_img_valid", b_valid, 1'b0);
            chk("rst_b_stat_valid", b_sv, 1'b0);
            chk("rst_b_sum", b_sum, 10'd0);
            chk("rst_b_count", b_cnt, 3'd0);
            chk("rst_b_threshold", b_thr, 8'd128);
        end else if (!cke_q) begin
            chk("a_stat_valid_hold", a_sv, sv_prev_a);
            chk("b_stat_valid_hold", b_sv, sv_prev_b);
        end else begin
            if (a_valid || b_valid) begin
                if (pix_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pixel: got valid output, expected none");
                end else begin
                    ep = pix_q.pop_front();
                    chk("a_img_valid", a_valid, 1'b1);
                    chk("b_img_valid", b_valid, 1'b1);
                    cmp_pix("a_img", a_lf, a_ll, a_pf, a_pl, a_de, a_user, a_gray, a_bin, ep);
                    cmp_pix("b_img", b_lf, b_ll, b_pf, b_pl, b_de, b_user, b_gray, b_bin, ep);
                end
            end
            if (a_sv || b_sv) begin
                if (stat_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_stat_strobe: got strobe, expected none");
                end else begin
                    es = stat_q.pop_front();
                    chk("a_stat_valid", a_sv, 1'b1);
                    chk("b_stat_valid", b_sv, 1'b1);
                    cmp_stat("a_stat", a_min, a_max, 64'(a_sum), 64'(a_cnt), a_thr, es, 32, 24);
                    cmp_stat("b_stat", b_min, b_max, 64'(b_sum), 64'(b_cnt), b_thr, es, 10, 3);
                end
            end
        end
        sv_prev_a = a_sv;
        sv_prev_b = b_sv;
    end

    initial begin
        int w, h, n;
        pat = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd200};
        reset = 1'b1; cke = 1'b1; valid = 1'b0; de = 1'b0; user = 1'b0; gray = 8'd0;
        lf = 1'b0; ll = 1'b0; pf = 1'b0; pl = 1'b0;
        cke_mode = 1'b0; gap_mode = 1'b0; model_thr = 128;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        load_pattern();
        send_frame(4, 2, 0, 8);
        idle(2);
        send_frame(4, 2, 0, 8);
        load_pattern();
        fr_de[0] = 1'b0;
        fr_de[7] = 1'b0;
        send_frame(4, 2, 0, 8);
        idle(2);

        fr_gray[0] = 8'd77;
        fr_de[0]   = 1'b1;
        send_frame(1, 1, 0, 1);
        idle(1);
        load_pattern();
        for (int i = 0; i < 8; i++) fr_de[i] = 1'b0;
        send_frame(4, 2, 0, 8);
        idle(2);

        cke_mode = 1'b1;
        gap_mode = 1'b1;
        load_pattern();
        send_frame(4, 2, 0, 8);
        send_frame(4, 2, 0, 8);
        idle(4);

        for (int i = 0; i < 12; i++) begin
            fr_gray[i] = 8'd255;
            fr_de[i]   = 1'b1;
        end
        send_frame(4, 3, 0, 12);
        idle(3);

        load_pattern();
        send_frame(4, 2, 0, 3);
        do_reset();
        send_frame(4, 2, 1, 8);
        idle(2);
        send_frame(4, 2, 0, 8);
        idle(2);

        for (int f = 0; f < 30; f++) begin
            cke_mode = ($urandom_range(0, 1) != 0);
            gap_mode = ($urandom_range(0, 1) != 0);
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, w * h) : w * h;
            for (int i = 0; i < w * h; i++) begin
                fr_gray[i] = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
                fr_de[i]   = ($urandom_range(0, 4) != 0);
            end
            send_frame(w, h, 0, n);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end

        cke_mode = 1'b0;
        idle(4);
        done = 1'b1;
    end

endmodule
